// File: rtl/lsu.sv
// Load/store unit: one outstanding bus transfer, byte-lane enables,
// load sign/zero formatting, alignment faults and a bounded ack wait.
module lsu #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] result,
   input  logic [XLEN-1:0] reg_out,
   input  logic            mm_we,
   input  logic            mm_re,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_valid,
   output logic            busy,
   output logic            fault,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_be,
   input  logic            bus_ack,
   input  logic [XLEN-1:0] bus_rdata
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_f3;
   logic [1:0]      r_lo;
   logic [XLEN-1:0] r_rd_data;
   logic            r_rd_valid;
   logic            r_fault;
   logic            r_bus_req;
   logic            r_bus_we;
   logic [XLEN-1:0] r_bus_addr;
   logic [XLEN-1:0] r_bus_wdata;
   logic [3:0]      r_bus_be;

   logic            w_mem;
   logic            w_f3_ok;
   logic            w_align;
   logic            w_legal;
   logic            w_go;
   logic            w_tmo;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_lane;
   logic [XLEN-1:0] w_load;

   assign w_mem   = mm_we | mm_re;
   assign w_align = ~((funct3[1:0] == 2'b01 & result[0]) |
                      (funct3[1:0] == 2'b10 & |result[1:0]));
   assign w_legal = w_f3_ok & w_align;
   assign w_go    = (r_state == S_IDLE) & w_mem & w_legal;
   assign w_tmo   = ~bus_ack & (r_cnt == CW'(TIMEOUT - 1));
   assign busy    = ~rst & (w_go | (r_state == S_BUS));

   // Unsigned widths exist only for loads
   always_comb begin
      w_f3_ok = 1'b0;
      unique case (funct3)
         3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
         3'b100, 3'b101:         w_f3_ok = ~mm_we;
         default:                w_f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = reg_out;
      unique case (funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << result[1:0];
            w_wdata = {(XLEN/8){reg_out[7:0]}};
         end
         2'b01: begin
            w_be    = result[1] ? 4'b1100 : 4'b0011;
            w_wdata = {(XLEN/16){reg_out[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = reg_out;
         end
      endcase
      if (!mm_we)
         w_wdata = '0;
   end

   assign w_lane = bus_rdata >> {r_lo, 3'b000};

   always_comb begin
      w_load = bus_rdata;
      unique case (r_f3[1:0])
         2'b00:   w_load = {{(XLEN-8){w_lane[7] & ~r_f3[2]}},
                            w_lane[7:0]};
         2'b01:   w_load = {{(XLEN-16){w_lane[15] & ~r_f3[2]}},
                            w_lane[15:0]};
         default: w_load = bus_rdata;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_go) w_next = S_BUS;
         S_BUS:   if (bus_ack || w_tmo) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_f3        <= '0;
         r_lo        <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_fault     <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= '0;
      end else begin
         r_rd_valid <= 1'b0;
         r_fault    <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (!w_mem) begin
                  r_rd_data  <= result;
                  r_rd_valid <= 1'b1;
               end else if (!w_legal) begin
                  r_fault <= 1'b1;
               end else begin
                  r_cnt       <= '0;
                  r_f3        <= funct3;
                  r_lo        <= result[1:0];
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= mm_we;
                  r_bus_addr  <= {result[XLEN-1:2], 2'b00};
                  r_bus_wdata <= w_wdata;
                  r_bus_be    <= w_be;
               end
            end
            S_BUS: begin
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  if (!r_bus_we) begin
                     r_rd_data  <= w_load;
                     r_rd_valid <= 1'b1;
                  end
               end else if (w_tmo) begin
                  r_bus_req <= 1'b0;
                  r_fault   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign fault     = r_fault;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_be    = r_bus_be;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu; writeback/fault pulses are checked against a
// scoreboard queue filled as each operation is driven.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  funct3;
   logic [31:0] result;
   logic [31:0] reg_out;
   logic        mm_we;
   logic        mm_re;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   typedef struct packed {
      logic        f;
      logic [31:0] d;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   logic [31:0] m_rd;
   int          checks = 0;
   int          errors = 0;

   lsu #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .funct3    (funct3),
      .result    (result),
      .reg_out   (reg_out),
      .mm_we     (mm_we),
      .mm_re     (mm_re),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .fault     (fault),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_be    (bus_be),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every writeback or fault pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rd_valid | fault) begin
         chk("excl", {31'b0, rd_valid & fault}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'b0, rd_valid, fault}, 32'd0);
         end else begin
            m_e = sb.pop_front();
            chk("sb_kind", {30'b0, rd_valid, fault},
                m_e.f ? 32'd1 : 32'd2);
            chk("sb_data", rd_data, m_e.d);
         end
      end
   end

   task automatic nm(input logic [31:0] v);
      mm_we  = 1'b0;
      mm_re  = 1'b0;
      result = v;
      sb.push_back('{1'b0, v});
      m_rd = v;
      #1 chk("nm.busy", {31'b0, busy}, 32'd0);
      step();
   endtask

   task automatic bad(input string tag, input logic we,
                      input logic [2:0] f3, input logic [31:0] a);
      mm_we  = we;
      mm_re  = ~we;
      funct3 = f3;
      result = a;
      sb.push_back('{1'b1, m_rd});
      #1 chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
      step();
      chk({tag, ".req"}, {31'b0, bus_req}, 32'd0);
      chk({tag, ".busy2"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic mem(input string tag, input logic we,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input int k,
                      input logic [31:0] rdat, input logic [3:0] ebe,
                      input logic [31:0] ewd, input logic [31:0] erd);
      mm_we     = we;
      mm_re     = ~we;
      funct3    = f3;
      result    = a;
      reg_out   = d;
      bus_ack   = 1'b0;
      bus_rdata = 32'h5A5A5A5A;
      #1 chk({tag, ".busy_acc"}, {31'b0, busy}, 32'd1);
      if (!we) begin
         sb.push_back('{1'b0, erd});
         m_rd = erd;
      end
      step();
      for (int i = 1; i <= k; i++) begin
         chk({tag, ".req"}, {31'b0, bus_req}, 32'd1);
         chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
         chk({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
         chk({tag, ".be"}, {28'b0, bus_be}, {28'b0, ebe});
         chk({tag, ".wdata"}, bus_wdata, ewd);
         chk({tag, ".we"}, {31'b0, bus_we}, {31'b0, we});
         if (i == k) begin
            bus_ack   = 1'b1;
            bus_rdata = rdat;
         end
         step();
         bus_ack   = 1'b0;
         bus_rdata = 32'h5A5A5A5A;
      end
      chk({tag, ".done_req"}, {31'b0, bus_req}, 32'd0);
      chk({tag, ".done_busy"}, {31'b0, busy}, 32'd0);
      if (we) chk({tag, ".rd_keep"}, rd_data, m_rd);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      funct3    = 3'b000;
      result    = '0;
      reg_out   = '0;
      mm_we     = 1'b0;
      mm_re     = 1'b0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      m_rd      = '0;
      step();
      step();
      chk("rst.rd_data", rd_data, 32'd0);
      chk("rst.rd_valid", {31'b0, rd_valid}, 32'd0);
      chk("rst.fault", {31'b0, fault}, 32'd0);
      chk("rst.req", {31'b0, bus_req}, 32'd0);
      chk("rst.we", {31'b0, bus_we}, 32'd0);
      chk("rst.be", {28'b0, bus_be}, 32'd0);
      chk("rst.addr", bus_addr, 32'd0);
      chk("rst.wdata", bus_wdata, 32'd0);
      mm_re  = 1'b1;
      funct3 = 3'b010;
      result = 32'h40;
      #1 chk("rst.busy", {31'b0, busy}, 32'd0);
      step();
      chk("rst.no_req", {31'b0, bus_req}, 32'd0);

      rst = 1'b0;
      nm(32'hDEADBEEF);
      chk("nm.rd_data", rd_data, 32'hDEADBEEF);
      nm(32'h12345678);
      nm(32'h00000000);

      mem("lb", 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80000000,
          4'b1000, 32'h0, 32'hFFFFFF80);
      mem("sh", 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0,
          4'b1100, 32'hABCDABCD, 32'h0);
      bad("lw_mis", 1'b0, 3'b010, 32'h101);
      bad("lh_mis", 1'b0, 3'b001, 32'h5);
      bad("sh_mis", 1'b1, 3'b001, 32'h3);
      bad("sw_mis", 1'b1, 3'b010, 32'h2);
      bad("sbu_ill", 1'b1, 3'b100, 32'h0);
      bad("f3_011", 1'b0, 3'b011, 32'h0);
      nm(32'hA5A5_0001);
      mem("lhu", 1'b0, 3'b101, 32'h2, 32'h0, 3, 32'h87654321,
          4'b1100, 32'h0, 32'h00008765);
      mem("lh", 1'b0, 3'b001, 32'h0, 32'h0, 1, 32'h0000F00D,
          4'b0011, 32'h0, 32'hFFFFF00D);
      mem("sb", 1'b1, 3'b000, 32'h1, 32'h000000AA, 2, 32'h0,
          4'b0010, 32'hAAAAAAAA, 32'h0);
      mem("sw", 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 1, 32'h0,
          4'b1111, 32'hCAFEF00D, 32'h0);
      mem("lw", 1'b0, 3'b010, 32'h20, 32'h0, 2, 32'h11223344,
          4'b1111, 32'h0, 32'h11223344);
      mem("lbu", 1'b0, 3'b100, 32'h2, 32'h0, 1, 32'h00AB0000,
          4'b0100, 32'h0, 32'h000000AB);
      mem("lb_pos", 1'b0, 3'b000, 32'h1, 32'h0, 1, 32'h00007F00,
          4'b0010, 32'h0, 32'h0000007F);

      mm_we  = 1'b0;
      mm_re  = 1'b1;
      funct3 = 3'b010;
      result = 32'h40;
      sb.push_back('{1'b1, m_rd});
      #1 chk("tmo.busy_acc", {31'b0, busy}, 32'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("tmo.req", {31'b0, bus_req}, 32'd1);
         step();
      end
      chk("tmo.req_off", {31'b0, bus_req}, 32'd0);
      chk("tmo.done_busy", {31'b0, busy}, 32'd0);
      step();
      nm(32'h0000_1111);

      mm_re  = 1'b1;
      funct3 = 3'b010;
      result = 32'h80;
      #1;
      step();
      step();
      chk("abort.req_bus2", {31'b0, bus_req}, 32'd1);
      rst = 1'b1;
      #1 chk("abort.busy", {31'b0, busy}, 32'd0);
      step();
      m_rd = 32'd0;
      chk("abort.req", {31'b0, bus_req}, 32'd0);
      chk("abort.rd_data", rd_data, 32'd0);
      chk("abort.rd_valid", {31'b0, rd_valid}, 32'd0);
      chk("abort.fault", {31'b0, fault}, 32'd0);
      chk("abort.addr", bus_addr, 32'd0);
      chk("abort.be", {28'b0, bus_be}, 32'd0);
      chk("abort.wdata", bus_wdata, 32'd0);
      rst = 1'b0;
      mem("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 2, 32'hFF000000,
          4'b1000, 32'h0, 32'h000000FF);
      nm(32'h0BAD_F00D);
      @(negedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: XLEN, default 32, data/address width.
REQ-002 Parameter: TIMEOUT, default 255, maximum cycles in BUS waiting for bus_ack.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 funct3  in  3  memory access width/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-007 result  in  XLEN  effective address for memory ops, writeback value otherwise.
REQ-008 reg_out  in  XLEN  store data.
REQ-009 mm_we  in  1  store request.
REQ-010 mm_re  in  1  load request.
REQ-011 rd_data  out  XLEN  registered writeback data.
REQ-012 rd_valid  out  1  rd_data carries a new writeback value this cycle.
REQ-013 busy  out  1  combinational; upstream SHALL hold all inputs stable while high.
REQ-014 fault  out  1  one-cycle pulse: misaligned, illegal funct3 or bus timeout.
REQ-015 bus_req, bus_we  out  1 each  bus request / write qualifier.
REQ-016 bus_addr  out  XLEN  word-aligned address {result[XLEN-1:2],2'b00}.
REQ-017 bus_wdata  out  XLEN; bus_be  out  4  write data, byte-lane enables.
REQ-018 bus_ack  in  1; bus_rdata  in  XLEN  transfer complete / read data (valid when ack).

Function
REQ-019 FSM states: IDLE, BUS, DONE.
REQ-020 IDLE, mm_we=mm_re=0: next edge rd_data<=result, rd_valid=1; stay IDLE; busy=0.
REQ-021 IDLE, mm_we=1 or mm_re=1 (mm_we wins if both), legal and aligned: busy=1 this cycle; next edge latch bus_addr/be/wdata/we, bus_req=1, go BUS.
REQ-022 Alignment: halfword needs result[0]=0; word needs result[1:0]=00; byte always legal.
REQ-023 Misaligned or funct3 not in {000,001,010,100,101} (stores: {000,001,010}): no bus transaction; next edge fault=1 for one cycle, rd_valid=0, rd_data unchanged; stay IDLE; busy=0.
REQ-024 bus_be: byte 1<<result[1:0]; half 0011 (result[1]=0) or 1100; word 1111; same encoding for loads.
REQ-025 bus_wdata: SB byte replicated x4, SH halfword replicated x2, SW reg_out; 0 for loads.
REQ-026 BUS: bus_req=1, busy=1; all bus outputs held stable until ack cycle inclusive.
REQ-027 BUS, bus_ack=1: next edge bus_req=0, go DONE; load: rd_data<=formatted bus_rdata; store: rd_data unchanged.
REQ-028 Load format: select lane by latched address[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-029 bus_ack allowed in the first BUS cycle (one BUS cycle minimum); bus_ack ignored outside BUS.
REQ-030 Wait counter reset on entry to BUS, increments each BUS cycle without ack; at TIMEOUT cycles without ack: next edge bus_req=0, fault pulse, rd_data unchanged, go DONE.
REQ-031 DONE: busy=0; rd_valid=1 only for completed load; inputs ignored this cycle (held instruction not re-accepted); next edge go IDLE.
REQ-032 Latency: non-mem 1 cycle; load/store with ack in BUS cycle k = k+2 cycles from accept to DONE.
REQ-033 rd_valid and fault are single-cycle pulses, never high together.

Reset
REQ-034 On rst edge: state IDLE, rd_data=0, rd_valid=0, fault=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, counter=0.
REQ-035 busy=0 while rst high; rst in BUS aborts the transfer, and bus_req=0 from the next cycle with no fault.

Verification
REQ-036 LB result=0x103, bus_rdata=0x80000000, ack in 2nd BUS cycle -> bus_addr=0x100, be=1000, bus_we=0; DONE: rd_data=0xFFFFFF80, rd_valid=1.
REQ-037 SH result=0x202, reg_out=0x1234ABCD, immediate ack -> bus_addr=0x200, be=1100, wdata=0xABCDABCD, bus_we=1; DONE: rd_valid=0.
REQ-038 LW result=0x101 -> no bus_req, fault=1 next cycle for one cycle, busy=0 throughout.
REQ-039 Non-mem result=0xDEADBEEF -> next cycle rd_data=0xDEADBEEF, rd_valid=1, busy=0; back-to-back ops produce one rd_valid per cycle.
REQ-040 TIMEOUT=4, LW result=0x40, no ack -> bus_req high exactly 4 cycles, then fault pulse, DONE with rd_valid=0, IDLE after.
REQ-041 rst asserted in 2nd BUS cycle -> next cycle bus_req=0, all outputs at reset values, fault=0; subsequent LBU result=0x3 with bus_rdata=0xFF000000 -> rd_data=0x000000FF.
